gumnut_fetch_unit: RTL and testbench

//  Instruction fetch stage for the Gumnut core. It sits directly upstream of the instruction register.
//  - Owns the 12-bit program counter (PC) and the return-address stack.
//  - Reads 18-bit words from instruction memory using a req/ack handshake.
//  - Passes each fetched word to the IR via inst_e_o with a one-cycle ir_we_o strobe.
//  - Applies PC updates (branch, jump, jsb, ret) commanded by the control FSM.

---
 rtl/gumnut_fetch_unit.sv | 127 ++++++++++++
 tb/tb_gumnut_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gumnut_fetch_unit.sv
// Gumnut instruction fetch: owns PC and return-address stack, fetches over imem req/ack.
// Fetch latency is ack + 1 cycle; PC updates are only accepted while idle.
module gumnut_fetch_unit #(
    parameter int ADDR_W      = 12,
    parameter int INST_W      = 18,
    parameter int STACK_DEPTH = 8
) (
    input  logic              clkg,
    input  logic              rst,
    input  logic              fetch_req_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic              imem_rd_o,
    input  logic [INST_W-1:0] imem_data_i,
    input  logic              imem_ack_i,
    output logic [INST_W-1:0] inst_e_o,
    output logic              ir_we_o,
    output logic              fetch_done_o,
    input  logic              br_i,
    input  logic [7:0]        disp_i,
    input  logic              jmp_i,
    input  logic              jsb_i,
    input  logic              ret_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [3:0]        sp_o,
    output logic              stk_ovf_o,
    output logic              stk_unf_o
);

    localparam int         PTR_W = $clog2(STACK_DEPTH);
    localparam logic [3:0] FULL  = 4'(STACK_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, LOAD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
    logic [PTR_W-1:0]  top_q, top_d;   // next free slot; top-of-stack is top_q-1
    logic [PTR_W-1:0]  top_m1;
    logic [3:0]        cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        stack_d = stack_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        top_m1  = top_q - PTR_W'(1);

        case (state_q)
            IDLE: begin
                if (ret_i) begin
                    if (cnt_q == 4'd0) begin
                        unf_d = 1'b1;
                    end else begin
                        top_d = top_m1;
                        pc_d  = stack_q[top_m1];
                        cnt_d = cnt_q - 4'd1;
                    end
                end else if (jsb_i) begin
                    // Writing at the free slot when full lands on the oldest entry.
                    stack_d[top_q] = pc_q;
                    top_d          = top_q + PTR_W'(1);
                    pc_d           = addr_i;
                    if (cnt_q == FULL) ovf_d = 1'b1;
                    else               cnt_d = cnt_q + 4'd1;
                end else if (jmp_i) begin
                    pc_d = addr_i;
                end else if (br_i) begin
                    pc_d = pc_q + {{(ADDR_W-8){disp_i[7]}}, disp_i};
                end
                if (fetch_req_i) state_d = REQ;
            end
            REQ: begin
                if (imem_ack_i) begin
                    inst_d  = imem_data_i;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkg) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            top_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            stack_q <= stack_d;
        end
    end

    assign imem_addr_o  = pc_q;
    assign imem_rd_o    = (state_q == REQ);
    assign ir_we_o      = (state_q == LOAD);
    assign fetch_done_o = (state_q == LOAD);
    assign inst_e_o     = inst_q;
    assign pc_o         = pc_q;
    assign sp_o         = cnt_q;
    assign stk_ovf_o    = ovf_q;
    assign stk_unf_o    = unf_q;

endmodule

// File: tb/tb_gumnut_fetch_unit.sv
// Bench for gumnut_fetch_unit: directed scenarios plus random ops against a transaction-level model.
module tb_gumnut_fetch_unit;

    logic        clkg = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req_i = 1'b0;
    logic [11:0] imem_addr_o;
    logic        imem_rd_o;
    logic [17:0] imem_data_i = '0;
    logic        imem_ack_i = 1'b0;
    logic [17:0] inst_e_o;
    logic        ir_we_o;
    logic        fetch_done_o;
    logic        br_i = 1'b0;
    logic [7:0]  disp_i = '0;
    logic        jmp_i = 1'b0;
    logic        jsb_i = 1'b0;
    logic        ret_i = 1'b0;
    logic [11:0] addr_i = '0;
    logic [11:0] pc_o;
    logic [3:0]  sp_o;
    logic        stk_ovf_o;
    logic        stk_unf_o;

    always #5 clkg = ~clkg;

    gumnut_fetch_unit dut (
        .clkg(clkg), .rst(rst), .fetch_req_i(fetch_req_i),
        .imem_addr_o(imem_addr_o), .imem_rd_o(imem_rd_o),
        .imem_data_i(imem_data_i), .imem_ack_i(imem_ack_i),
        .inst_e_o(inst_e_o), .ir_we_o(ir_we_o), .fetch_done_o(fetch_done_o),
        .br_i(br_i), .disp_i(disp_i), .jmp_i(jmp_i), .jsb_i(jsb_i), .ret_i(ret_i),
        .addr_i(addr_i), .pc_o(pc_o), .sp_o(sp_o),
        .stk_ovf_o(stk_ovf_o), .stk_unf_o(stk_unf_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: PC, return stack as a bounded queue, sticky flags, last instruction.
    logic [11:0] m_pc;
    logic [11:0] m_stk[$];
    logic        m_ovf, m_unf;
    logic [17:0] m_inst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkg);
        #1;
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_inst = '0;
    endtask

    task automatic model_update(input bit ret, input bit jsb, input bit jmp, input bit br,
                                input logic [7:0] disp, input logic [11:0] addr);
        logic [11:0] sext;
        sext = {{4{disp[7]}}, disp};
        if (ret) begin
            if (m_stk.size() == 0) m_unf = 1'b1;
            else                   m_pc = m_stk.pop_back();
        end else if (jsb) begin
            if (m_stk.size() == 8) begin
                void'(m_stk.pop_front());
                m_ovf = 1'b1;
            end
            m_stk.push_back(m_pc);
            m_pc = addr;
        end else if (jmp) begin
            m_pc = addr;
        end else if (br) begin
            m_pc = m_pc + sext;
        end
    endtask

    task automatic check_arch(input string where);
        check({where, "_pc"},  pc_o,      m_pc);
        check({where, "_sp"},  sp_o,      m_stk.size());
        check({where, "_ovf"}, stk_ovf_o, m_ovf);
        check({where, "_unf"}, stk_unf_o, m_unf);
    endtask

    // One IDLE-cycle command (optional PC update and/or fetch), followed by the whole fetch if requested.
    task automatic do_op(input bit fetch, input bit ret, input bit jsb, input bit jmp, input bit br,
                         input logic [7:0] disp, input logic [11:0] addr,
                         input logic [17:0] data, input int lat, input bit noise);
        fetch_req_i = fetch; ret_i = ret; jsb_i = jsb; jmp_i = jmp; br_i = br;
        disp_i = disp; addr_i = addr;
        tick();
        fetch_req_i = 0; ret_i = 0; jsb_i = 0; jmp_i = 0; br_i = 0;
        model_update(ret, jsb, jmp, br, disp, addr);
        check_arch("upd");
        check("upd_rd", imem_rd_o, fetch);
        if (fetch) begin
            for (int i = 0; i < lat - 1; i++) begin
                check("wait_rd",   imem_rd_o,   1);
                check("wait_addr", imem_addr_o, m_pc);
                check("wait_we",   ir_we_o,     0);
                if (noise) begin
                    br_i = 1; disp_i = 8'($urandom); jmp_i = 1; addr_i = 12'($urandom);
                end
                tick();
                br_i = 0; jmp_i = 0;
            end
            check("ack_rd",   imem_rd_o,   1);
            check("ack_addr", imem_addr_o, m_pc);
            imem_ack_i = 1; imem_data_i = data;
            tick();
            imem_ack_i = 0; imem_data_i = 18'($urandom);
            m_inst = data;
            check("load_we",   ir_we_o,      1);
            check("load_done", fetch_done_o, 1);
            check("load_inst", inst_e_o,     m_inst);
            check("load_rd",   imem_rd_o,    0);
            check("load_pc",   pc_o,         m_pc);
            tick();
            m_pc = m_pc + 12'd1;
            check("post_we",   ir_we_o,      0);
            check("post_done", fetch_done_o, 0);
            check("post_inst", inst_e_o,     m_inst);
            check_arch("post");
        end
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, "_rd"},   imem_rd_o,    0);
        check({where, "_addr"}, imem_addr_o,  0);
        check({where, "_inst"}, inst_e_o,     0);
        check({where, "_we"},   ir_we_o,      0);
        check({where, "_done"}, fetch_done_o, 0);
        check_arch(where);
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        rst = 0;
        check_reset_outputs("rst");

        // Basic fetch, 1-cycle memory, then a 4-cycle-latency fetch with branch/jump noise.
        do_op(1, 0, 0, 0, 0, 8'h00, 12'h000, 18'h2A5F3, 1, 0);
        check("fetch1_pc", pc_o, 12'h001);
        do_op(1, 0, 0, 0, 0, 8'h00, 12'h000, 18'h13579, 4, 1);

        // Branch wrap below zero and PC+1 wrap at the top.
        do_op(0, 0, 0, 1, 0, 8'h00, 12'h002, '0, 1, 0);
        do_op(0, 0, 0, 0, 1, 8'hFC, 12'h000, '0, 1, 0);
        check("br_wrap", pc_o, 12'hFFE);
        do_op(0, 0, 0, 1, 0, 8'h00, 12'hFFF, '0, 1, 0);
        do_op(1, 0, 0, 0, 0, 8'h00, 12'h000, 18'h3FFFF, 2, 0);
        check("inc_wrap", pc_o, 12'h000);

        // Nine nested calls overflow the 8-deep stack; nine returns underflow it.
        for (int k = 0; k < 9; k++) do_op(0, 0, 1, 0, 0, 8'h00, 12'h100 + 12'(k), '0, 1, 0);
        check("ovf_set", stk_ovf_o, 1);
        for (int k = 0; k < 9; k++) do_op(0, 1, 0, 0, 0, 8'h00, 12'h000, '0, 1, 0);
        check("unf_set", stk_unf_o, 1);

        // ret outranks jmp; update and fetch in the same IDLE cycle.
        do_op(0, 0, 1, 0, 0, 8'h00, 12'h234, '0, 1, 0);
        do_op(0, 1, 0, 1, 0, 8'h00, 12'h777, '0, 1, 0);
        do_op(1, 0, 0, 1, 1, 8'h05, 12'h456, 18'h0BEEF, 2, 0);

        // Reset during REQ, with a late ack arriving once back in IDLE.
        fetch_req_i = 1;
        tick();
        fetch_req_i = 0;
        check("mid_rd_before", imem_rd_o, 1);
        rst = 1;
        tick();
        rst = 0;
        model_reset();
        check_reset_outputs("mid_rst");
        imem_ack_i = 1; imem_data_i = 18'h1ABCD;
        tick();
        imem_ack_i = 0;
        check_reset_outputs("late_ack");
        tick();
        check_reset_outputs("late_ack2");

        for (int n = 0; n < 300; n++) begin
            do_op(1'($urandom_range(0, 1)),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  8'($urandom), 12'($urandom), 18'($urandom),
                  $urandom_range(1, 5), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
